// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM state type and op-code validity check for alu_seq_unit
package alu_seq_pkg;

  localparam logic [4:0] ALUOP_SUB = 5'b00000;
  localparam logic [4:0] ALUOP_ADD = 5'b00001;
  localparam logic [4:0] ALUOP_MUL = 5'b00010;
  localparam logic [4:0] ALUOP_OR  = 5'b00011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_valid_op(input logic [4:0] op);
    return (op == ALUOP_SUB) || (op == ALUOP_ADD) ||
           (op == ALUOP_MUL) || (op == ALUOP_OR);
  endfunction

endpackage

// File: rtl/alu_seq_mul_step.sv
// rtl/alu_seq_mul_step.sv - one combinational shift-add multiply step
// i_neg subtracts the addend instead of adding it (sign weight of the top multiplier bit).
module alu_seq_mul_step #(
  parameter int AW = 32,
  parameter int BW = 32
) (
  input  logic [AW-1:0] i_acc,
  input  logic [AW-1:0] i_a_shift,
  input  logic [BW-1:0] i_b_shift,
  input  logic          i_neg,
  output logic [AW-1:0] o_acc,
  output logic [AW-1:0] o_a_shift,
  output logic [BW-1:0] o_b_shift
);

  logic [AW-1:0] w_addend;

  assign w_addend  = i_neg ? (~i_a_shift + AW'(1)) : i_a_shift;
  assign o_acc     = i_b_shift[0] ? (i_acc + w_addend) : i_acc;
  assign o_a_shift = i_a_shift << 1;
  assign o_b_shift = i_b_shift >> 1;

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - sequenced ALU front-end (add/sub/or single cycle, iterative mul)
// Optional macro ALU_SEQ_OVF_EN adds resp_ovf and widens the accumulator to 2*WIDTH.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_c,
  output logic             resp_zero,
  output logic             resp_err,
  output logic             busy
`ifdef ALU_SEQ_OVF_EN
  , output logic           resp_ovf
`endif
);

`ifdef ALU_SEQ_OVF_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, r_a_shift, w_acc_nxt, w_a_shift_nxt, w_a_ext;
  logic [WIDTH-1:0] r_b_shift, w_b_shift_nxt, w_op_a, w_exec_c, r_resp_c;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_last, w_neg, w_exec_err, r_resp_zero, r_resp_err;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_op_a   = r_a_shift[WIDTH-1:0];

`ifdef ALU_SEQ_OVF_EN
  logic w_exec_ovf, w_mul_ovf, r_resp_ovf;
  logic [WIDTH:0] w_mul_hi;
  // Signed multiply: A is sign-extended and the last (sign) bit of B carries weight -2^(WIDTH-1).
  assign w_a_ext   = {{WIDTH{req_a[WIDTH-1]}}, req_a};
  assign w_neg     = w_last;
  assign w_mul_hi  = w_acc_nxt[ACC_W-1:WIDTH-1];
  assign w_mul_ovf = !((&w_mul_hi) || !(|w_mul_hi));
  assign resp_ovf  = r_resp_ovf;
`else
  assign w_a_ext = req_a;
  assign w_neg   = 1'b0;
`endif

  alu_seq_mul_step #(.AW(ACC_W), .BW(WIDTH)) u_mul_step (
    .i_acc    (r_acc),
    .i_a_shift(r_a_shift),
    .i_b_shift(r_b_shift),
    .i_neg    (w_neg),
    .o_acc    (w_acc_nxt),
    .o_a_shift(w_a_shift_nxt),
    .o_b_shift(w_b_shift_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = (req_op == ALUOP_MUL) ? MUL : EXEC;
      EXEC: w_state_nxt = DONE;
      MUL:  if (w_last) w_state_nxt = DONE;
      DONE: if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_exec_c   = '0;
    w_exec_err = 1'b0;
`ifdef ALU_SEQ_OVF_EN
    w_exec_ovf = 1'b0;
`endif
    case (r_op)
      ALUOP_SUB: begin
        w_exec_c = w_op_a - r_b_shift;
`ifdef ALU_SEQ_OVF_EN
        w_exec_ovf = (w_op_a[WIDTH-1] != r_b_shift[WIDTH-1]) &&
                     (w_exec_c[WIDTH-1] != w_op_a[WIDTH-1]);
`endif
      end
      ALUOP_ADD: begin
        w_exec_c = w_op_a + r_b_shift;
`ifdef ALU_SEQ_OVF_EN
        w_exec_ovf = (w_op_a[WIDTH-1] == r_b_shift[WIDTH-1]) &&
                     (w_exec_c[WIDTH-1] != w_op_a[WIDTH-1]);
`endif
      end
      ALUOP_OR: w_exec_c = w_op_a | r_b_shift;
      default:  w_exec_err = !is_valid_op(r_op);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_a_shift   <= '0;
      r_b_shift   <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_resp_c    <= '0;
      r_resp_zero <= 1'b0;
      r_resp_err  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      r_resp_ovf  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_a_shift <= w_a_ext;
          r_b_shift <= req_b;
          r_op      <= req_op;
          r_acc     <= '0;
          r_cnt     <= '0;
        end
        EXEC: begin
          r_resp_c    <= w_exec_c;
          r_resp_zero <= (w_exec_c == '0);
          r_resp_err  <= w_exec_err;
`ifdef ALU_SEQ_OVF_EN
          r_resp_ovf  <= w_exec_ovf;
`endif
        end
        MUL: begin
          r_acc     <= w_acc_nxt;
          r_a_shift <= w_a_shift_nxt;
          r_b_shift <= w_b_shift_nxt;
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_resp_c    <= w_acc_nxt[WIDTH-1:0];
            r_resp_zero <= (w_acc_nxt[WIDTH-1:0] == '0);
            r_resp_err  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            r_resp_ovf  <= w_mul_ovf;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign resp_c     = r_resp_c;
  assign resp_zero  = r_resp_zero;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - scoreboard bench for alu_seq_unit (directed vectors)
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_op = '0;
  logic        req_ready, resp_valid, resp_zero, resp_err, busy;
  logic [31:0] resp_c;
`ifdef ALU_SEQ_OVF_EN
  logic        resp_ovf;
`endif

  alu_seq_unit #(.WIDTH(32), .OP_W(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_c    (resp_c),
    .resp_zero (resp_zero),
    .resp_err  (resp_err),
    .busy      (busy)
`ifdef ALU_SEQ_OVF_EN
    , .resp_ovf(resp_ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] c;
    logic        zero;
    logic        err;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   accept_cyc = 0;
  int   first_cyc = 0;
  bit   seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: records accept/first-valid cycles, pops and compares on each response handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      seen = 0;
    end else begin
      if (req_valid && req_ready) accept_cyc = cyc;
      if (resp_valid && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (resp_valid && !resp_ready && sb_q.size() > 0) check("hold_c", resp_c, sb_q[0].c);
      if (resp_valid && resp_ready) begin
        seen = 0;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got c=%0h expected no response", resp_c);
        end else begin
          e = sb_q.pop_front();
          check("resp_c", resp_c, e.c);
          check("resp_zero", resp_zero, e.zero);
          check("resp_err", resp_err, e.err);
          check("latency", first_cyc - accept_cyc, e.lat);
`ifdef ALU_SEQ_OVF_EN
          check("resp_ovf", resp_ovf, e.ovf);
`endif
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic [31:0] c, input logic z, input logic er, input logic o,
                       input int lat, input bit expect_resp);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got req_ready=0 expected 1");
      return;
    end
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    if (expect_resp) sb_q.push_back('{c: c, zero: z, err: er, ovf: o, lat: lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = 32'hDEADBEEF;
    req_b = 32'h12345678;
    req_op = ALUOP_ADD;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (sb_q.size() > 0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_c", resp_c, 0);
    check("rst_resp_zero", resp_zero, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 0);
`ifdef ALU_SEQ_OVF_EN
    check("rst_resp_ovf", resp_ovf, 0);
`endif
  endtask

  initial begin
    int bad;
    int n;
    int vcount;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rstn = 1'b1;
    resp_ready = 1'b1;

    issue(32'h7FFFFFFF, 32'd1, ALUOP_ADD, 32'h80000000, 1'b0, 1'b0, 1'b1, 2, 1);
    drain(50);
    issue(32'd5, 32'd5, ALUOP_SUB, 32'd0, 1'b1, 1'b0, 1'b0, 2, 1);
    drain(50);
    issue(32'hF0F0_0000, 32'h0000_0F0F, ALUOP_OR, 32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0, 2, 1);
    drain(50);

    issue(32'hFFFFFFFD, 32'd7, ALUOP_MUL, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0, 33, 1);
    bad = 0;
    n = 0;
    while (!resp_valid && n < 60) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
      @(posedge clk); #1;
      n++;
    end
    check("mul_busy_not_ready", bad, 0);
    drain(50);

    resp_ready = 1'b0;
    issue(32'd2, 32'd3, ALUOP_ADD, 32'd5, 1'b0, 1'b0, 1'b0, 2, 1);
    req_valid = 1'b1;
    req_a = 32'd100;
    req_b = 32'd200;
    req_op = ALUOP_ADD;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_req_ready_low", req_ready, 0);
      check("bp_resp_valid_held", resp_valid, 1);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", req_ready, 1);
    check("bp_valid_drop", resp_valid, 0);
    drain(10);
    issue(32'd10, 32'd20, ALUOP_ADD, 32'd30, 1'b0, 1'b0, 1'b0, 2, 1);
    drain(50);

    issue(32'd9, 32'd9, 5'b10101, 32'd0, 1'b1, 1'b1, 1'b0, 2, 1);
    drain(50);

    issue(32'd1234, 32'd5678, ALUOP_MUL, 32'd0, 1'b0, 1'b0, 1'b0, 33, 0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    rstn = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) vcount++;
    end
    check("rst_no_resp", vcount, 0);
    issue(32'd1, 32'd1, ALUOP_ADD, 32'd2, 1'b0, 1'b0, 1'b0, 2, 1);
    drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
